// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer. A flush empties it and may load one entry in the
// same cycle, which lets a fault marker replace the flushed contents directly.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    fetch_entry_t  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    // A pop frees the slot the same-cycle push lands in, so a full buffer may do both.
    assign do_push = push && (flush || !full || do_pop);
    assign wr_addr = flush ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? AW'(1) : '0;
            count  <= do_push ? (AW + 1)'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_addr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem read at a time, feeding a decode buffer.
// Build option FETCH_ALIGN_TRAP_EN turns misaligned redirects into a fault marker and halts fetch.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_misaligned
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  fetch_pc;
    logic [31:0]  fetch_pc_next;
    logic         stale;
    logic         stale_next;
    logic         outstanding_after;
    logic [31:0]  redirect_target;
    logic         redirect_bad;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head;

`ifdef FETCH_ALIGN_TRAP_EN
    assign redirect_target = i_redirect_pc;
    assign redirect_bad    = (i_redirect_pc[1:0] != 2'b00);
    assign o_misaligned    = !fifo_empty && head.misaligned;
`else
    logic unused_align_bits;
    assign redirect_target   = {i_redirect_pc[31:2], 2'b00};
    assign redirect_bad      = 1'b0;
    assign o_misaligned      = 1'b0;
    assign unused_align_bits = ^{head.misaligned, i_redirect_pc[1:0]};
`endif

    // A request still in flight after this cycle; HALT remembers it in stale so its ack is dropped.
    assign outstanding_after = ((state == WAIT) || (state == DROP) || stale) && !i_imem_ack;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            stale    <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            stale    <= stale_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        stale_next    = stale && !i_imem_ack;
        o_imem_req    = 1'b0;
        fifo_push     = 1'b0;
        push_entry    = '{instr: i_imem_data, pc: fetch_pc, misaligned: 1'b0};

        case (state)
            IDLE: begin
                if (!i_rst && !i_redirect && !fifo_full) begin
                    o_imem_req = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (i_imem_ack) begin
                    state_next    = IDLE;
                    fifo_push     = 1'b1;
                    fetch_pc_next = fetch_pc + 32'd4;
                end else if (i_redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (i_imem_ack) state_next = IDLE;
            end
            HALT: begin
                if (i_redirect) state_next = stale_next ? DROP : IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Redirect wins over ack, pop and any new request.
        if (i_redirect) begin
            fetch_pc_next = redirect_target;
            fifo_push     = 1'b0;
            if (redirect_bad) begin
                state_next = HALT;
                stale_next = outstanding_after;
                fifo_push  = 1'b1;
                push_entry = '{instr: 32'h0, pc: i_redirect_pc, misaligned: 1'b1};
            end
        end
    end

    assign fifo_pop = i_ready && !fifo_empty && !i_redirect;

    fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .flush    (i_redirect),
        .push     (fifo_push),
        .push_data(push_entry),
        .pop      (fifo_pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign o_imem_addr = fetch_pc;
    assign o_valid     = !fifo_empty;
    assign o_instr     = fifo_empty ? 32'h0 : head.instr;
    assign o_pc        = fifo_empty ? 32'h0 : head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, multi-cycle corner sequences and a
// randomized run against an occupancy/stream model of the fetch rules.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misaligned;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (RPC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_data  (imem_data),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_instr      (instr),
        .o_pc         (pc),
        .o_misaligned (misaligned)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Memory responder state
    bit          pend = 1'b0;
    bit          pend_stale = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_wait = 0;
    int          lat_max = 0;
    int          lat_fix = 0;
    logic [31:0] data_xor = '0;

    // Reference model: buffered count, next fetch address, next expected decode pc
    bit          model_on = 1'b1;
    int          m_occ = 0;
    logic [31:0] m_fetch = RPC;
    logic [31:0] m_exp = RPC;

    typedef struct {
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rdy, input logic v, input logic [31:0] p,
                       input logic rq, input logic [31:0] a);
        vec_t r;
        r.rdy = rdy; r.exp_valid = v; r.exp_pc = p; r.exp_req = rq; r.exp_addr = a;
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later, advance model and memory.
    task automatic step(input logic rdy, input logic rd, input logic [31:0] rdpc);
        logic exp_req;
        bit   pop;
        @(negedge clk);
        rst = 1'b0; ready = rdy; redirect = rd; redirect_pc = rdpc;
        imem_ack = 1'b0; imem_data = '0;
        if (pend) begin
            if (pend_wait == 0) begin
                imem_ack  = 1'b1;
                imem_data = pend_addr ^ data_xor;
            end else begin
                pend_wait--;
            end
        end
        #1;
        if (model_on) begin
            check("valid", 32'(valid), 32'(m_occ > 0));
            if (m_occ > 0) begin
                check("head_pc", pc, m_exp);
                check("head_instr", instr, m_exp ^ data_xor);
                check("head_misaligned", 32'(misaligned), 32'h0);
            end
            exp_req = !pend && (m_occ < DEPTH) && !rd;
            check("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) check("imem_addr", imem_addr, m_fetch);
            pop = (m_occ > 0) && rdy;
            if (rd) begin
                m_occ   = 0;
                m_fetch = rdpc & 32'hFFFF_FFFC;
                m_exp   = m_fetch;
                if (pend && !imem_ack) pend_stale = 1'b1;
            end else begin
                if (imem_ack && !pend_stale) begin
                    m_occ++;
                    m_fetch += 32'd4;
                end
                if (pop) begin
                    m_occ--;
                    m_exp += 32'd4;
                end
            end
        end
        if (imem_ack) begin
            pend = 1'b0;
            pend_stale = 1'b0;
        end
        if (imem_req) begin
            pend       = 1'b1;
            pend_addr  = imem_addr;
            pend_stale = 1'b0;
            pend_wait  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(lat_max, 0));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_data = '0;
        pend = 1'b0; pend_stale = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_misaligned", 32'(misaligned), 32'h0);
        m_occ = 0; m_fetch = RPC; m_exp = RPC;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            step(1'b1, 1'b0, 32'h0);
            if (valid) begin
                seen = 1'b1;
                check(name, pc, exp_pc);
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no output within 30 cycles, want pc %h", name, exp_pc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] got[$];
        int          consumed;
        logic        rd;
        logic [31:0] rdpc;

        // Zero-wait memory returning the address; decode always ready, then stalled 10 cycles.
        add(1, 0, 32'h0,  1, 32'h0);
        add(1, 0, 32'h0,  0, 32'h0);
        add(1, 1, 32'h0,  1, 32'h4);
        add(1, 0, 32'h0,  0, 32'h0);
        add(1, 1, 32'h4,  1, 32'h8);
        add(1, 0, 32'h0,  0, 32'h0);
        add(1, 1, 32'h8,  1, 32'hC);
        add(1, 0, 32'h0,  0, 32'h0);
        add(1, 1, 32'hC,  1, 32'h10);
        add(0, 0, 32'h0,  0, 32'h0);
        add(0, 1, 32'h10, 1, 32'h14);
        for (int k = 0; k < 8; k++) add(0, 1, 32'h10, 0, 32'h0);
        add(1, 1, 32'h10, 0, 32'h0);
        add(1, 1, 32'h14, 1, 32'h18);
        add(1, 0, 32'h0,  0, 32'h0);
        add(1, 1, 32'h18, 1, 32'h1C);

        rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_data = '0;
        data_xor = 32'h0; lat_fix = 0; model_on = 1'b1;
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].rdy, 1'b0, 32'h0);
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
                check($sformatf("vec%0d_instr", i), instr, tbl[i].exp_pc);
            end
            check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) check($sformatf("vec%0d_addr", i), imem_addr, tbl[i].exp_addr);
        end

        // Redirect while the fetch of 0x8 is outstanding: its ack must be discarded.
        do_reset();
        lat_fix = 0;
        repeat (4) step(1'b1, 1'b0, 32'h0);
        lat_fix = 3;
        step(1'b1, 1'b0, 32'h0);
        check("drop_req_addr", imem_addr, 32'h8);
        lat_fix = 0;
        step(1'b1, 1'b1, 32'h100);
        step(1'b1, 1'b0, 32'h0);
        check("drop_no_req", 32'(imem_req), 32'h0);
        wait_valid("drop_next_pc", 32'h100);

        // Redirect in the same cycle as an ack and a pop.
        do_reset();
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h300);
        check("same_cycle_pre_valid", 32'(valid), 32'h1);
        step(1'b1, 1'b0, 32'h0);
        check("same_cycle_flush", 32'(valid), 32'h0);
        check("same_cycle_req_addr", imem_addr, 32'h300);
        wait_valid("same_cycle_next_pc", 32'h300);

        // Fetch address wrap at the top of the address space.
        do_reset();
        lat_fix = -1; lat_max = 2; data_xor = 32'hDEAD_0000;
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int k = 0; k < 40 && got.size() < 3; k++) begin
            step(1'b1, 1'b0, 32'h0);
            if (valid) got.push_back(pc);
        end
        while (got.size() < 3) got.push_back(32'hBAD0_BAD0);
        check("wrap_pc0", got[0], 32'hFFFF_FFF8);
        check("wrap_pc1", got[1], 32'hFFFF_FFFC);
        check("wrap_pc2", got[2], 32'h0000_0000);

`ifdef FETCH_ALIGN_TRAP_EN
        // Misaligned redirect: one fault marker, then no fetching until an aligned redirect.
        do_reset();
        lat_fix = 1; data_xor = 32'h0; model_on = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h102);
        step(1'b1, 1'b0, 32'h0);
        check("trap_valid", 32'(valid), 32'h1);
        check("trap_pc", pc, 32'h102);
        check("trap_flag", 32'(misaligned), 32'h1);
        check("trap_instr", instr, 32'h0);
        check("trap_req", 32'(imem_req), 32'h0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 32'h0);
            check("halt_req", 32'(imem_req), 32'h0);
            check("halt_valid", 32'(valid), 32'h0);
        end
        m_occ = 0; model_on = 1'b1; lat_fix = 0;
        step(1'b1, 1'b1, 32'h200);
        wait_valid("trap_resume_pc", 32'h200);
`else
        // Misaligned redirect target is realigned; no fault marker exists.
        do_reset();
        lat_fix = 0; data_xor = 32'h0;
        step(1'b1, 1'b1, 32'h102);
        wait_valid("align_forced_pc", 32'h100);
        check("align_no_flag", 32'(misaligned), 32'h0);
`endif

        // Randomized traffic with a mid-run reset.
        do_reset();
        model_on = 1'b1; lat_fix = -1; lat_max = 3; data_xor = 32'h5A5A_1234;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            rd   = ($urandom_range(15, 0) == 0);
            rdpc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
            step(($urandom_range(3, 0) != 0), rd, rdpc);
        end
        consumed = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (valid) consumed++;
        end
        check("drain_progress", 32'(consumed > 0), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
